// File: rtl/fir_decim_scale.sv
// +--------------------------------------------------------------------------+
// | fir_decim_scale                                                          |
// | Decimates the FIR accumulator stream, rounds/saturates to the output     |
// | width and presents it on an AXI-Stream master through a 2-entry skid.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fir_decim_scale #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 16,
    parameter int DECIM                  = 4,
    parameter int SHIFT                  = 8
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_areset,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    output logic                                  sat_flag
);

    localparam int c_in_w   = C_S00_AXIS_TDATA_WIDTH;
    localparam int c_out_w  = C_M00_AXIS_TDATA_WIDTH;
    localparam int c_strb_w = C_M00_AXIS_TDATA_WIDTH / 8;
    localparam int c_ph_w   = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [c_ph_w-1:0]     c_ph_last = c_ph_w'(DECIM - 1);
    localparam logic signed [c_in_w:0] c_half   = {{c_in_w{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [c_in_w:0] c_max    = {{(c_in_w - c_out_w + 2){1'b0}}, {(c_out_w - 1){1'b1}}};
    localparam logic signed [c_in_w:0] c_min    = {{(c_in_w - c_out_w + 2){1'b1}}, {(c_out_w - 1){1'b0}}};

    logic                   r_s_tready;
    logic [c_ph_w-1:0]      r_phase;
    logic                   r_m_valid;
    logic [c_out_w-1:0]     r_m_data;
    logic                   r_m_last;
    logic                   r_s_valid;
    logic [c_out_w-1:0]     r_s_data;
    logic                   r_s_last;
    logic                   r_sat;

    logic                   w_in_fire;
    logic                   w_keep;
    logic                   w_m_free;
    logic signed [c_in_w:0] w_ext;
    logic signed [c_in_w:0] w_rnd;
    logic signed [c_in_w:0] w_shr;
    logic                   w_hi;
    logic                   w_lo;
    logic [c_out_w-1:0]     w_scaled;
    logic [c_ph_w-1:0]      w_phase_nxt;
    logic                   w_m_valid_nxt;
    logic [c_out_w-1:0]     w_m_data_nxt;
    logic                   w_m_last_nxt;
    logic                   w_s_valid_nxt;
    logic [c_out_w-1:0]     w_s_data_nxt;
    logic                   w_s_last_nxt;
    logic                   w_unused;

    assign w_unused  = ^s00_axis_tstrb;

    assign w_in_fire = s00_axis_tvalid & r_s_tready;
    assign w_keep    = w_in_fire & ((r_phase == '0) | s00_axis_tlast);
    assign w_m_free  = ~r_m_valid | m00_axis_tready;

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign w_ext    = {s00_axis_tdata[c_in_w-1], s00_axis_tdata};
    assign w_rnd    = w_ext + c_half;
    assign w_shr    = w_rnd >>> SHIFT;
    assign w_hi     = (w_shr > c_max);
    assign w_lo     = (w_shr < c_min);
    assign w_scaled = w_hi ? c_max[c_out_w-1:0] :
                      w_lo ? c_min[c_out_w-1:0] : w_shr[c_out_w-1:0];

    always_comb begin
        w_phase_nxt   = r_phase;
        w_m_valid_nxt = r_m_valid;
        w_m_data_nxt  = r_m_data;
        w_m_last_nxt  = r_m_last;
        w_s_valid_nxt = r_s_valid;
        w_s_data_nxt  = r_s_data;
        w_s_last_nxt  = r_s_last;

        if (w_in_fire) begin
            if (s00_axis_tlast || (r_phase == c_ph_last)) begin
                w_phase_nxt = '0;
            end else begin
                w_phase_nxt = r_phase + c_ph_w'(1);
            end
        end

        if (w_m_free) begin
            if (r_s_valid) begin
                w_m_valid_nxt = 1'b1;
                w_m_data_nxt  = r_s_data;
                w_m_last_nxt  = r_s_last;
                if (w_keep) begin
                    w_s_data_nxt = w_scaled;
                    w_s_last_nxt = s00_axis_tlast;
                end else begin
                    w_s_valid_nxt = 1'b0;
                end
            end else if (w_keep) begin
                w_m_valid_nxt = 1'b1;
                w_m_data_nxt  = w_scaled;
                w_m_last_nxt  = s00_axis_tlast;
            end else begin
                w_m_valid_nxt = 1'b0;
                w_m_last_nxt  = 1'b0;
            end
        end else if (w_keep) begin
            w_s_valid_nxt = 1'b1;
            w_s_data_nxt  = w_scaled;
            w_s_last_nxt  = s00_axis_tlast;
        end
    end

    // tready tracks the post-edge skid occupancy, so a beat parked in S blocks
    // the very next accept and nothing can be overwritten.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_s_tready <= 1'b0;
            r_phase    <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
            r_s_valid  <= 1'b0;
            r_s_data   <= '0;
            r_s_last   <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_s_tready <= ~w_s_valid_nxt;
            r_phase    <= w_phase_nxt;
            r_m_valid  <= w_m_valid_nxt;
            r_m_data   <= w_m_data_nxt;
            r_m_last   <= w_m_last_nxt;
            r_s_valid  <= w_s_valid_nxt;
            r_s_data   <= w_s_data_nxt;
            r_s_last   <= w_s_last_nxt;
            r_sat      <= r_sat | (w_keep & (w_hi | w_lo));
        end
    end

    assign s00_axis_tready = r_s_tready;
    assign m00_axis_tvalid = r_m_valid;
    assign m00_axis_tdata  = r_m_data;
    assign m00_axis_tlast  = r_m_last;
    assign m00_axis_tstrb  = {c_strb_w{r_m_valid}};
    assign sat_flag        = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_fir_decim_scale.sv
// +--------------------------------------------------------------------------+
// | tb_fir_decim_scale                                                       |
// | Scoreboard bench for fir_decim_scale (DECIM=4 and DECIM=1 instances).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fir_decim_scale;

    localparam int SH = 8;

    logic        clk;
    logic        rst;
    logic        s_tvalid;
    logic        s_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        m_ready;
    logic        sel4;

    logic        d1_tready, d1_valid, d1_last, d1_sat;
    logic [15:0] d1_data;
    logic [1:0]  d1_strb;
    logic        d4_tready, d4_valid, d4_last, d4_sat;
    logic [15:0] d4_data;
    logic [1:0]  d4_strb;

    logic        w_tready, w_valid, w_last, w_sat;
    logic [15:0] w_data;
    logic [1:0]  w_strb;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] in_data[$];
    logic        in_last[$];
    int          n_pass;
    int          n_total;
    bit          exp_sat;
    int          cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fir_decim_scale #(.C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(16),
                      .DECIM(1), .SHIFT(SH)) dut1 (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(d1_tready),
        .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(d1_valid), .m00_axis_tready(m_ready),
        .m00_axis_tdata(d1_data), .m00_axis_tstrb(d1_strb), .m00_axis_tlast(d1_last),
        .sat_flag(d1_sat)
    );

    fir_decim_scale #(.C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(16),
                      .DECIM(4), .SHIFT(SH)) dut4 (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(d4_tready),
        .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(d4_valid), .m00_axis_tready(m_ready),
        .m00_axis_tdata(d4_data), .m00_axis_tstrb(d4_strb), .m00_axis_tlast(d4_last),
        .sat_flag(d4_sat)
    );

    assign w_tready = sel4 ? d4_tready : d1_tready;
    assign w_valid  = sel4 ? d4_valid  : d1_valid;
    assign w_last   = sel4 ? d4_last   : d1_last;
    assign w_sat    = sel4 ? d4_sat    : d1_sat;
    assign w_data   = sel4 ? d4_data   : d1_data;
    assign w_strb   = sel4 ? d4_strb   : d1_strb;

    function automatic logic [15:0] scale(input logic [31:0] x, output bit clip);
        longint v;
        v = longint'($signed(x));
        v = (v + (longint'(1) << (SH - 1))) >>> SH;
        clip = 1'b0;
        if (v > 32767) begin
            v = 32767;
            clip = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            clip = 1'b1;
        end
        return v[15:0];
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_ready  = 1'b0;
        exp_sat  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Streams in_data/in_last into the selected DUT; model fills the scoreboard
    // on accept, outputs are popped and compared on each downstream handshake.
    task automatic run_stream(input int ready_pct, input bit chk_lat, input int dec,
                              output int outs);
        int          idx;
        int          ph;
        int          budget;
        int          n;
        bit          held_v;
        bit          clip;
        logic [15:0] held_d;
        logic        held_l;
        exp_t        e;
        idx = 0; ph = 0; budget = 0; outs = 0; held_v = 1'b0;
        held_d = '0; held_l = 1'b0;
        n = in_data.size();
        while (1) begin
            s_tvalid = (idx < n);
            if (idx < n) begin
                s_tdata = in_data[idx];
                s_tlast = in_last[idx];
            end else begin
                s_tlast = 1'b0;
            end
            m_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            cyc++;
            if (held_v) begin
                n_total++;
                if (!w_valid || w_data !== held_d || w_last !== held_l)
                    $display("FAIL hold_stable: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             w_valid, w_data, w_last, held_d, held_l);
                else n_pass++;
            end
            if (w_valid) begin
                n_total++;
                if (w_strb !== 2'b11) $display("FAIL tstrb: got %b exp 11", w_strb);
                else n_pass++;
            end
            if (w_valid && m_ready) begin
                outs++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_out: got %0d exp none", $signed(w_data));
                end else begin
                    e = exp_q.pop_front();
                    if (w_data !== e.data || w_last !== e.last)
                        $display("FAIL out_data: got %0d last=%b exp %0d last=%b",
                                 $signed(w_data), w_last, $signed(e.data), e.last);
                    else n_pass++;
                    if (chk_lat) begin
                        n_total++;
                        if (cyc - e.cyc != 1)
                            $display("FAIL latency: got %0d exp 1", cyc - e.cyc);
                        else n_pass++;
                    end
                end
            end
            held_v = w_valid && !m_ready;
            held_d = w_data;
            held_l = w_last;
            if (s_tvalid && w_tready) begin
                if (ph == 0 || s_tlast) begin
                    e.data = scale(s_tdata, clip);
                    e.last = s_tlast;
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                    exp_sat = exp_sat | clip;
                end
                ph = (s_tlast || ph == dec - 1) ? 0 : ph + 1;
                idx++;
            end
            budget++;
            if (idx == n && exp_q.size() == 0) break;
            if (budget > 2000) begin
                n_total++;
                $display("FAIL timeout: got %0d pending exp 0", exp_q.size());
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        n_total++;
        if (w_sat !== exp_sat) $display("FAIL sat_flag_end: got %b exp %b", w_sat, exp_sat);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_total++; if (d4_valid !== 1'b0) $display("FAIL rst_tvalid: got %b exp 0", d4_valid); else n_pass++;
        n_total++; if (d4_data !== 16'h0) $display("FAIL rst_tdata: got %h exp 0", d4_data); else n_pass++;
        n_total++; if (d4_last !== 1'b0) $display("FAIL rst_tlast: got %b exp 0", d4_last); else n_pass++;
        n_total++; if (d4_strb !== 2'b00) $display("FAIL rst_tstrb: got %b exp 00", d4_strb); else n_pass++;
        n_total++; if (d4_sat !== 1'b0) $display("FAIL rst_sat: got %b exp 0", d4_sat); else n_pass++;
        n_total++; if (d1_tready !== 1'b0) $display("FAIL rst_tready: got %b exp 0", d1_tready); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_total++; if (d4_tready !== 1'b0) $display("FAIL rel_tready_early: got %b exp 0", d4_tready); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (d4_tready !== 1'b1) $display("FAIL rel_tready: got %b exp 1", d4_tready); else n_pass++;
    endtask

    task automatic test_frame();
        int outs;
        sel4 = 1'b1;
        do_reset();
        in_data.delete(); in_last.delete();
        for (int k = 0; k < 12; k++) begin
            in_data.push_back(32'(256 * k));
            in_last.push_back(k == 11);
        end
        run_stream(100, 1'b1, 4, outs);
        n_total++; if (outs != 4) $display("FAIL frame_count: got %0d exp 4", outs); else n_pass++;
    endtask

    task automatic test_rounding();
        int outs;
        sel4 = 1'b0;
        do_reset();
        in_data.delete(); in_last.delete();
        in_data.push_back(32'd127);  in_last.push_back(1'b0);
        in_data.push_back(32'd128);  in_last.push_back(1'b0);
        in_data.push_back(-32'sd128); in_last.push_back(1'b0);
        in_data.push_back(-32'sd129); in_last.push_back(1'b1);
        run_stream(100, 1'b1, 1, outs);
        n_total++; if (outs != 4) $display("FAIL round_count: got %0d exp 4", outs); else n_pass++;
    endtask

    task automatic test_saturation();
        int outs;
        sel4 = 1'b0;
        do_reset();
        in_data.delete(); in_last.delete();
        in_data.push_back(32'h7FFF_FFFF); in_last.push_back(1'b0);
        in_data.push_back(32'h8000_0000); in_last.push_back(1'b0);
        in_data.push_back(32'd256);       in_last.push_back(1'b0);
        in_data.push_back(-32'sd256);     in_last.push_back(1'b1);
        run_stream(100, 1'b1, 1, outs);
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (d1_sat !== 1'b1) $display("FAIL sat_sticky: got %b exp 1", d1_sat); else n_pass++;
    endtask

    task automatic test_backpressure();
        int outs;
        sel4 = 1'b0;
        do_reset();
        in_data.delete(); in_last.delete();
        for (int k = 0; k < 64; k++) begin
            in_data.push_back(32'(k << 8));
            in_last.push_back(k == 63);
        end
        run_stream(50, 1'b0, 1, outs);
        n_total++; if (outs != 64) $display("FAIL bp_count: got %0d exp 64", outs); else n_pass++;
    endtask

    task automatic test_short_frames();
        int outs;
        int lens[3];
        sel4 = 1'b1;
        do_reset();
        lens[0] = 1; lens[1] = 5; lens[2] = 4;
        in_data.delete(); in_last.delete();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < lens[f]; i++) begin
                in_data.push_back(32'((f * 16 + i + 1) << 8));
                in_last.push_back(i == lens[f] - 1);
            end
        end
        run_stream(60, 1'b0, 4, outs);
        n_total++; if (outs != 5) $display("FAIL short_count: got %0d exp 5", outs); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int acc;
        int outs;
        sel4 = 1'b1;
        do_reset();
        acc      = 0;
        m_ready  = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = 32'h1000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!w_tready) break;
            acc++;
            @(posedge clk);
            #1 s_tdata = s_tdata + 32'h100;
        end
        n_total++; if (acc != 2) $display("FAIL fill_accepts: got %0d exp 2", acc); else n_pass++;
        n_total++; if (w_valid !== 1'b1 || w_data !== 16'd16)
            $display("FAIL fill_head: got v=%b d=%0d exp v=1 d=16", w_valid, w_data); else n_pass++;
        #2 rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        n_total++; if (w_valid !== 1'b0) $display("FAIL mid_rst_tvalid: got %b exp 0", w_valid); else n_pass++;
        n_total++; if (w_data !== 16'h0 || w_last !== 1'b0 || w_strb !== 2'b00)
            $display("FAIL mid_rst_out: got d=%h l=%b s=%b exp 0", w_data, w_last, w_strb); else n_pass++;
        n_total++; if (w_tready !== 1'b0) $display("FAIL mid_rst_tready: got %b exp 0", w_tready); else n_pass++;
        exp_q.delete();
        exp_sat = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++; if (w_tready !== 1'b1) $display("FAIL post_rst_tready: got %b exp 1", w_tready); else n_pass++;
        in_data.delete(); in_last.delete();
        for (int k = 0; k < 5; k++) begin
            in_data.push_back(32'((k + 3) << 8));
            in_last.push_back(k == 4);
        end
        run_stream(100, 1'b1, 4, outs);
        n_total++; if (outs != 2) $display("FAIL post_rst_count: got %0d exp 2", outs); else n_pass++;
    endtask

    initial begin
        rst      = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tstrb  = 4'hF;
        m_ready  = 1'b0;
        sel4     = 1'b1;
        n_pass   = 0;
        n_total  = 0;
        exp_sat  = 1'b0;
        cyc      = 0;
        #2;
        test_reset();
        test_frame();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_short_frames();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_decim_scale.md
# fir_decim_scale

Downstream stage of the 15-tap FIR. Takes the 32-bit signed FIR accumulator stream, keeps one sample in every DECIM, and rescales it to a 16-bit signed output with round-half-up and saturation. It emits an AXI-Stream with full backpressure support through a 2-entry skid buffer, so it can feed the DMA/packetiser without combinational tready paths.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 32, input sample width (signed)
- C_M00_AXIS_TDATA_WIDTH, 16, output sample width (signed); must be < C_S00_AXIS_TDATA_WIDTH
- DECIM, 4, decimation factor, 1..256
- SHIFT, 8, right-shift applied before saturation, 1..C_S00_AXIS_TDATA_WIDTH-1
- s00_axis_aclk  in  1  single clock for both interfaces
- s00_axis_areset  in  1  reset, asynchronous, active-high
- s00_axis_tvalid  in  1  input beat valid
- s00_axis_tready  out  1  input ready (registered)
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  signed FIR output
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored
- s00_axis_tlast  in  1  end of frame
- m00_axis_tvalid  out  1  output beat valid
- m00_axis_tready  in  1  downstream ready
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  scaled, decimated sample
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  all ones whenever tvalid=1, 0 otherwise
- m00_axis_tlast  out  1  end of frame
- sat_flag  out  1  sticky: set when any kept sample saturated; cleared only by reset

## Operation
- Accept: in_fire = s00_axis_tvalid & s00_axis_tready.
- Phase counter `phase` runs 0..DECIM-1 and advances on each in_fire.
  - After DECIM-1 it wraps to 0.
  - On an in_fire with tlast=1 it returns to 0, whatever its current value.
- Keep rule: a beat is kept if phase==0 or tlast==1. Every other beat is dropped and has no output effect.
  - A tlast beat is always emitted, with m00_axis_tlast=1.
  - A frame of L beats therefore produces ceil(L/DECIM) outputs, plus 1 if (L-1) mod DECIM != 0.
- Scaling, per kept beat:
  - Compute in C_S00_AXIS_TDATA_WIDTH+1 bits: r = (x + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift).
  - Saturate to [-2^(OUT-1), 2^(OUT-1)-1]. A clipped result sets sat_flag.
  - The rounding add never wraps, because of the extra bit.
- Output buffering: main register M (drives m00_*) and skid register S.
  - Kept beat, M empty or being drained this cycle: the beat loads M.
  - Kept beat, M full and stalled: the beat loads S.
  - M drained while S full: S moves to M.
- DECIM=1: every beat is kept; the block is a pure scaler.

## Timing
- Reset (async assert, sync release) sets:
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, m00_axis_tstrb=0.
  - sat_flag=0, phase=0, S empty.
  - s00_axis_tready=0 while reset is asserted; 1 on the first clock edge after release.
- Latency: a kept beat accepted at edge N appears on m00_* after edge N (1 cycle), if M is empty or draining.
- s00_axis_tready is a register and equals "S empty" as of the previous edge. No combinational path from m00_axis_tready.
- Simultaneous kept-beat accept and M drain with S empty: the new beat goes straight to M, and tvalid stays 1 (back-to-back).
- M full and stalled, S empty, kept beat arrives: the beat goes to S, and tready drops the next cycle. No beat is lost.
- Dropped beats are accepted at full rate even when M is stalled, provided tready=1.
- Once asserted, m00_axis_tvalid, tdata and tlast hold stable until m00_axis_tready=1 (AXI rule).
- Reset asserted mid-frame: outputs clear immediately. Any buffered beats and the partial phase are discarded.
- Throughput: 1 input beat/cycle sustained when m00_axis_tready=1.

## Test plan
- DECIM=4, SHIFT=8, ready always 1. Input x=256·k, k=0..11, tlast on k=11 -> outputs 0, 4, 8, then 11 with tlast=1. Each output 1 cycle after its input; tstrb=2'b11.
- Rounding with DECIM=1, SHIFT=8. Inputs 127, 128, -128, -129 -> 0, 1, 0, -1.
- Saturation with DECIM=1, SHIFT=8. Inputs 0x7FFF_FFFF and 0x8000_0000 -> 32767 and -32768; sat_flag becomes 1 and stays 1 through further in-range beats.
- Backpressure with DECIM=1. Input continuous ramp 0..63 (<<8); m00_axis_tready pseudo-random 50% -> output exactly 0..63 in order with no duplicates. s00_axis_tready never drops for more than the stall length +1. tdata is stable whenever valid&!ready.
- Short frames with DECIM=4. Frames of length 1, 5, 4 -> outputs with tlast: [b0(last)]; [b0, b4(last)]; [b0, b3(last)]. phase restarts at 0 each frame.
- Async reset mid-stream, asserted between edges with M and S both full -> all outputs 0 immediately. After release the first beat is treated as phase 0 and appears 1 cycle after acceptance.
